// File: rtl/md_pkg.sv
//------------------------------------------------------------------------------
// Module : md_pkg
// Brief  : Shared types for the HI/LO multiply/divide sequencing controller.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package md_pkg;

  localparam int MD_OPW = 3;

  typedef enum logic [MD_OPW-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MF    = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/hilo_regs.sv
//------------------------------------------------------------------------------
// Module : hilo_regs
// Brief  : Architectural HI/LO storage with an MT write port, an engine result
//          write port and the MF read mux.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mt_hi_we,
  input  logic             mt_lo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             res_we,
  input  logic [WIDTH-1:0] res_h,
  input  logic [WIDTH-1:0] res_l,
  input  logic             mf_en,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Result writes and MT writes are mutually exclusive at the controller level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (res_we) begin
      hi_q <= res_h;
      lo_q <= res_l;
    end else begin
      if (mt_hi_we) hi_q <= mt_data;
      if (mt_lo_we) lo_q <= mt_data;
    end
  end

  assign mf_data = mf_en ? (mf_sel ? hi_q : lo_q) : '0;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

`default_nettype wire

// File: rtl/hilo_md_ctrl.sv
//------------------------------------------------------------------------------
// Module : hilo_md_ctrl
// Brief  : Sequencer between EX and the shared mul/div engine. Decodes
//          MULT/MULTU/DIV/DIVU/MTHI/MTLO/MF, holds md_enable until the engine
//          answers, stalls IF..EX meanwhile and aborts on flush.
// Config : MD_DIVZERO_FAST_EN - divide by zero completes in the accept cycle
//          (hi<=src_a, lo<=all ones) without ever enabling the engine.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hilo_md_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [MD_OPW-1:0] op,
  input  logic              mf_sel,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  input  logic              flush,
  output logic [WIDTH-1:0]  md_a,
  output logic [WIDTH-1:0]  md_b,
  output logic              md_mult,
  output logic              md_signed,
  output logic              md_enable,
  input  logic              md_ready,
  input  logic [WIDTH-1:0]  md_res_h,
  input  logic [WIDTH-1:0]  md_res_l,
  output logic              stall,
  output logic [WIDTH-1:0]  mf_data,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  md_state_e        state_q;
  logic [WIDTH-1:0] md_a_q;
  logic [WIDTH-1:0] md_b_q;
  logic             md_mult_q;
  logic             md_signed_q;
  logic             md_enable_q;

  md_op_e           op_e;
  logic             accept;
  logic             is_md;
  logic             is_div;
  logic             div_zero_fast;
  logic             issue;
  logic             done;
  logic             res_we;
  logic [WIDTH-1:0] res_h;
  logic [WIDTH-1:0] res_l;

  assign op_e   = md_op_e'(op);
  assign accept = op_valid & ~flush & (state_q == IDLE);
  assign is_md  = (op_e == MD_MULT) | (op_e == MD_MULTU) |
                  (op_e == MD_DIV)  | (op_e == MD_DIVU);
  assign is_div = (op_e == MD_DIV) | (op_e == MD_DIVU);

`ifdef MD_DIVZERO_FAST_EN
  assign div_zero_fast = accept & is_div & (src_b == '0);
`else
  assign div_zero_fast = 1'b0;
`endif

  assign issue = accept & is_md & ~div_zero_fast;
  // A flush in BUSY wins over a coincident ready: the result is dropped.
  assign done  = (state_q == BUSY) & md_ready & ~flush;

  // Stall covers the accept cycle and every BUSY cycle that cannot retire.
  assign stall = (state_q == IDLE) ? issue : (~md_ready & ~flush);

  // Issue/complete/abort sequencing with registered engine-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      md_a_q      <= '0;
      md_b_q      <= '0;
      md_mult_q   <= 1'b0;
      md_signed_q <= 1'b0;
      md_enable_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q     <= BUSY;
            md_a_q      <= src_a;
            md_b_q      <= src_b;
            md_mult_q   <= (op_e == MD_MULT) | (op_e == MD_MULTU);
            md_signed_q <= (op_e == MD_MULT) | (op_e == MD_DIV);
            md_enable_q <= 1'b1;
          end
        end
        BUSY: begin
          // Dropping enable is the engine's only abort indication.
          if (flush | md_ready) begin
            state_q     <= IDLE;
            md_enable_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          md_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_we = done | div_zero_fast;
  assign res_h  = div_zero_fast ? src_a : md_res_h;
  assign res_l  = div_zero_fast ? {WIDTH{1'b1}} : md_res_l;

  hilo_regs #(
    .WIDTH (WIDTH)
  ) u_hilo_regs (
    .clk      (clk),
    .rst      (rst),
    .mt_hi_we (accept & (op_e == MD_MTHI)),
    .mt_lo_we (accept & (op_e == MD_MTLO)),
    .mt_data  (src_a),
    .res_we   (res_we),
    .res_h    (res_h),
    .res_l    (res_l),
    .mf_en    (accept & (op_e == MD_MF)),
    .mf_sel   (mf_sel),
    .mf_data  (mf_data),
    .hi       (hi),
    .lo       (lo)
  );

  assign md_a      = md_a_q;
  assign md_b      = md_b_q;
  assign md_mult   = md_mult_q;
  assign md_signed = md_signed_q;
  assign md_enable = md_enable_q;

endmodule

`default_nettype wire

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Sequencing controller between the EX stage and the shared multiply/divide engine.
- Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO and latches operands.
- Holds the engine enable until the engine reports ready, stalls the pipeline meanwhile, and owns the architectural HI/LO registers.
- Handles exception flush by aborting an in-flight operation with no HI/LO update.

Parameters:
- WIDTH, 32, operand and HI/LO width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  EX stage holds a valid instruction this cycle.
- op  in  3  md_op_e code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MF=7.
- mf_sel  in  1  for MF: 0 selects LO, 1 selects HI.
- src_a  in  WIDTH  rs operand.
- src_b  in  WIDTH  rt operand.
- flush  in  1  exception/ERET flush; kills the EX instruction and any in-flight operation.
- md_a  out  WIDTH  registered operand a to the engine.
- md_b  out  WIDTH  registered operand b to the engine.
- md_mult  out  1  1 = multiply, 0 = divide.
- md_signed  out  1  signed operation.
- md_enable  out  1  held high for the whole operation.
- md_ready  in  1  engine result valid.
- md_res_h  in  WIDTH  engine high result.
- md_res_l  in  WIDTH  engine low result.
- stall  out  1  freeze IF..EX.
- mf_data  out  WIDTH  MF read data.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (async, rst=1): state=IDLE; hi, lo, md_a, md_b = 0; md_mult, md_signed, md_enable = 0.
- Reset mid-BUSY: abort immediately with no HI/LO write.
- accept = op_valid & ~flush & (state==IDLE).
- State IDLE:
  - accept with MULT/MULTU/DIV/DIVU: latch src_a/src_b into md_a/md_b, set md_mult and md_signed, go to BUSY. md_enable is 1 from the next cycle.
  - stall = 1 combinationally in the accept cycle of a mul/div.
  - accept MTHI or MTLO: write hi or lo from src_a at the clock edge; no stall.
  - accept MF: mf_data = mf_sel ? hi : lo, combinational; no stall.
- State BUSY:
  - md_enable = 1.
  - stall = ~md_ready.
  - md_ready=1: capture hi<=md_res_h, lo<=md_res_l, md_enable<=0, go to IDLE. Stall drops the same cycle, so the instruction retires.
  - Minimum mul/div occupancy: 2 cycles (accept + one BUSY cycle), even if the engine answers combinationally.
- flush=1 in BUSY, including a cycle where md_ready=1:
  - flush wins; no HI/LO write; md_enable<=0; go to IDLE; stall=0 that cycle.
  - Dropping md_enable is the only abort signal the engine gets.
- flush in IDLE: op is ignored; no register changes.
- After an abort, the engine must see md_enable low for at least one cycle before the next issue. Guaranteed because BUSY->IDLE takes one edge.
- Divide by zero (no macro): issued normally; HI/LO take whatever the engine returns.
- mf_data is defined only for op=MF; otherwise it is 0.
- Unknown op or NONE: no action.

Optional Feature:
- Macro: MD_DIVZERO_FAST_EN.
- Defined: DIV/DIVU with src_b==0 does not enter BUSY and never raises md_enable. At the accept edge hi<=src_a and lo<={WIDTH{1'b1}}; no stall.
- Undefined: divide by zero takes the normal engine path.

Decomposition:
- Package md_pkg:
  - md_op_e enum (values above).
  - md_state_e {IDLE, BUSY}.
  - localparam MD_OPW=3.
- Sub-module hilo_regs (HI/LO storage, MT write port, result write port, MF read mux) is natural.
- FSM and stall logic stay in hilo_md_ctrl.

Test Plan:
- MULT src_a=0xFFFF_FFFE, src_b=3, engine ready one cycle after enable -> stall high exactly 2 cycles; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; md_signed=1, md_mult=1.
- DIVU src_a=100, src_b=7, engine ready after 34 cycles -> stall high 35 cycles; md_enable high continuously; lo=14, hi=2; then MF mf_sel=0 -> mf_data=14.
- DIV in flight, flush pulsed 5 cycles into BUSY -> md_enable low next cycle; hi/lo keep prior values (0x1111/0x2222); next DIV accepted after one IDLE cycle.
- flush coincident with md_ready -> no HI/LO update; state IDLE; stall 0.
- MTHI 0xDEAD_BEEF then MF mf_sel=1 next cycle -> mf_data=0xDEAD_BEEF, no stall. Assert rst mid-BUSY -> hi=lo=0 and md_enable=0 asynchronously.
- With MD_DIVZERO_FAST_EN: DIV src_a=0x1234, src_b=0 -> md_enable never asserts, no stall, hi=0x1234, lo=0xFFFF_FFFF.
